// File: rtl/bin2dec_fmt_if.sv
// Request/result bundle between a value producer and bin2dec_fmt.
// The master side issues conversion requests and consumes the formatted
// characters. The slave side is the converter itself.
interface bin2dec_fmt_if;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] value;
  logic        blank_lz;
  logic        dp_en;
  logic [1:0]  dp_pos;
  logic [31:0] data_out;
  logic [3:0]  dot_out;
  logic        out_valid;

  modport master (
    output in_valid, value, blank_lz, dp_en, dp_pos,
    input  in_ready, data_out, dot_out, out_valid
  );

  modport slave (
    input  in_valid, value, blank_lz, dp_en, dp_pos,
    output in_ready, data_out, dot_out, out_valid
  );
endinterface

// File: rtl/bin2dec_fmt.sv
// 14-bit binary to 4-digit ASCII converter for the seven-segment driver.
// Uses sequential double dabble, one bit per clock, and then formats the
// result with optional leading-zero blanking and a decimal point. The last
// result is held on data_out/dot_out until the next conversion completes.
module bin2dec_fmt #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  bin2dec_fmt_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FMT   = 2'd2;

  localparam logic [3:0]  LAST_ITER = 4'd13;
  localparam logic [13:0] MAX_VALUE = 14'd9999;

  logic [1:0]  state;
  logic [29:0] shift_reg;
  logic [3:0]  iter;
  logic [13:0] lat_value;
  logic        lat_blank;
  logic        lat_dp_en;
  logic [1:0]  lat_dp_pos;

  logic [29:0] adjusted;
  logic [31:0] fmt_data;
  logic [3:0]  fmt_dot;
  logic        leading;
  logic [3:0]  digit;
  logic        keep;

  // The clock frequency is informational only and drives no logic.
  logic unused_clk_freq;
  assign unused_clk_freq = (CLK_FREQ != 0);

  assign bus.in_ready = (state == IDLE);

  // Add 3 to every BCD nibble that is 5 or more before the next left shift.
  always_comb begin
    adjusted = shift_reg;
    for (int i = 0; i < 4; i++) begin
      if (shift_reg[14 + 4*i +: 4] >= 4'd5)
        adjusted[14 + 4*i +: 4] = shift_reg[14 + 4*i +: 4] + 4'd3;
    end
  end

  // Turn the finished BCD digits into ASCII, blanking leading zeros down to
  // the first nonzero digit; the ones digit and the decimal-point digit (and
  // everything below it) always stay visible.
  always_comb begin
    fmt_data = 32'h0;
    fmt_dot  = 4'b0000;
    leading  = 1'b1;
    digit    = 4'd0;
    keep     = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      digit = shift_reg[14 + 4*i +: 4];
      keep  = (i == 0) || (lat_dp_en && (2'(i) <= lat_dp_pos));
      if (lat_blank && leading && (digit == 4'd0) && !keep) begin
        fmt_data[i*8 +: 8] = 8'h20;
      end else begin
        fmt_data[i*8 +: 8] = 8'h30 + {4'd0, digit};
        leading = 1'b0;
      end
    end
    if (lat_dp_en)
      fmt_dot = 4'b0001 << lat_dp_pos;
    if (lat_value > MAX_VALUE) begin
      fmt_data = 32'h2D2D2D2D;
      fmt_dot  = 4'b0000;
    end
  end

  // Control FSM: accept a request, run 14 shift-add-3 steps, then publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shift_reg     <= 30'd0;
      iter          <= 4'd0;
      lat_value     <= 14'd0;
      lat_blank     <= 1'b0;
      lat_dp_en     <= 1'b0;
      lat_dp_pos    <= 2'd0;
      bus.data_out  <= 32'h20202020;
      bus.dot_out   <= 4'b0000;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            lat_value  <= bus.value;
            lat_blank  <= bus.blank_lz;
            lat_dp_en  <= bus.dp_en;
            lat_dp_pos <= bus.dp_pos;
            shift_reg  <= {16'd0, bus.value};
            iter       <= 4'd0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= {adjusted[28:0], 1'b0};
          iter      <= iter + 4'd1;
          if (iter == LAST_ITER)
            state <= FMT;
        end
        FMT: begin
          bus.data_out  <= fmt_data;
          bus.dot_out   <= fmt_dot;
          bus.out_valid <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2dec_fmt.sv
// Directed self-checking bench for bin2dec_fmt.
module tb_bin2dec_fmt;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bin2dec_fmt_if bus ();

  bin2dec_fmt #(.CLK_FREQ(50_000_000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one request and follow it to its out_valid pulse (bounded wait).
  // lat = cycles from accept edge to the edge that raised out_valid, 0 if none.
  // busy = sampled cycles with in_ready low before the pulse.
  task automatic run_conv(input logic [13:0] v, input logic bl, input logic de,
                          input logic [1:0] dp, output int lat, output int busy,
                          output logic [31:0] d, output logic [3:0] dt,
                          output logic ov_after);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.value    = v;
    bus.blank_lz = bl;
    bus.dp_en    = de;
    bus.dp_pos   = dp;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.value    = 14'h3FFF;
    bus.blank_lz = ~bl;
    bus.dp_en    = ~de;
    bus.dp_pos   = ~dp;
    lat = 0; busy = 0; d = '0; dt = '0; ov_after = 1'b1;
    if (!bus.in_ready) busy++;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = k;
        d   = bus.data_out;
        dt  = bus.dot_out;
      end else if (!bus.in_ready) begin
        busy++;
      end
    end
    if (lat != 0) begin
      @(posedge clk);
      #1;
      ov_after = bus.out_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.value = '0; bus.blank_lz = 1'b0; bus.dp_en = 1'b0; bus.dp_pos = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.data_out !== 32'h20202020) begin errors++; $display("[TB] FAIL reset_data: got %h expected 20202020", bus.data_out); end
    checks++; if (bus.dot_out !== 4'b0000) begin errors++; $display("[TB] FAIL reset_dot: got %b expected 0000", bus.dot_out); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_plain();
    int lat, busy; logic [31:0] d; logic [3:0] dt; logic ova;
    run_conv(14'd1234, 1'b0, 1'b0, 2'd0, lat, busy, d, dt, ova);
    checks++; if (lat !== 15) begin errors++; $display("[TB] FAIL plain_latency: got %0d expected 15", lat); end
    checks++; if (d !== 32'h31323334) begin errors++; $display("[TB] FAIL plain_data: got %h expected 31323334", d); end
    checks++; if (dt !== 4'b0000) begin errors++; $display("[TB] FAIL plain_dot: got %b expected 0000", dt); end
    checks++; if (busy !== 15) begin errors++; $display("[TB] FAIL plain_busy: got %0d expected 15", busy); end
    checks++; if (ova !== 1'b0) begin errors++; $display("[TB] FAIL plain_pulse_width: out_valid got %b expected 0 one cycle later", ova); end
    checks++; if (bus.data_out !== 32'h31323334) begin errors++; $display("[TB] FAIL plain_hold: got %h expected 31323334", bus.data_out); end
  endtask

  task automatic test_blanking();
    int lat, busy; logic [31:0] d; logic [3:0] dt; logic ova;
    run_conv(14'd42, 1'b1, 1'b0, 2'd0, lat, busy, d, dt, ova);
    checks++; if (d !== 32'h20203432) begin errors++; $display("[TB] FAIL blank_42: got %h expected 20203432", d); end
    run_conv(14'd0, 1'b1, 1'b0, 2'd0, lat, busy, d, dt, ova);
    checks++; if (d !== 32'h20202030) begin errors++; $display("[TB] FAIL blank_zero: got %h expected 20202030", d); end
    run_conv(14'd42, 1'b0, 1'b0, 2'd0, lat, busy, d, dt, ova);
    checks++; if (d !== 32'h30303432) begin errors++; $display("[TB] FAIL noblank_42: got %h expected 30303432", d); end
  endtask

  task automatic test_decimal_point();
    int lat, busy; logic [31:0] d; logic [3:0] dt; logic ova;
    run_conv(14'd5, 1'b1, 1'b1, 2'd2, lat, busy, d, dt, ova);
    checks++; if (d !== 32'h20303035) begin errors++; $display("[TB] FAIL dp_blank_data: got %h expected 20303035", d); end
    checks++; if (dt !== 4'b0100) begin errors++; $display("[TB] FAIL dp_blank_dot: got %b expected 0100", dt); end
    run_conv(14'd50, 1'b1, 1'b1, 2'd0, lat, busy, d, dt, ova);
    checks++; if (d !== 32'h20203530) begin errors++; $display("[TB] FAIL dp0_data: got %h expected 20203530", d); end
    checks++; if (dt !== 4'b0001) begin errors++; $display("[TB] FAIL dp0_dot: got %b expected 0001", dt); end
    run_conv(14'd1234, 1'b0, 1'b1, 2'd3, lat, busy, d, dt, ova);
    checks++; if (dt !== 4'b1000) begin errors++; $display("[TB] FAIL dp3_dot: got %b expected 1000", dt); end
  endtask

  task automatic test_overflow();
    int lat, busy; logic [31:0] d; logic [3:0] dt; logic ova;
    run_conv(14'd9999, 1'b0, 1'b0, 2'd0, lat, busy, d, dt, ova);
    checks++; if (d !== 32'h39393939) begin errors++; $display("[TB] FAIL max_9999: got %h expected 39393939", d); end
    run_conv(14'd10000, 1'b1, 1'b1, 2'd1, lat, busy, d, dt, ova);
    checks++; if (d !== 32'h2D2D2D2D) begin errors++; $display("[TB] FAIL ovf_10000_data: got %h expected 2D2D2D2D", d); end
    checks++; if (dt !== 4'b0000) begin errors++; $display("[TB] FAIL ovf_10000_dot: got %b expected 0000", dt); end
    run_conv(14'd16383, 1'b0, 1'b0, 2'd0, lat, busy, d, dt, ova);
    checks++; if (d !== 32'h2D2D2D2D) begin errors++; $display("[TB] FAIL ovf_16383_data: got %h expected 2D2D2D2D", d); end
    checks++; if (lat !== 15) begin errors++; $display("[TB] FAIL ovf_latency: got %0d expected 15", lat); end
  endtask

  task automatic test_back_to_back();
    int acc_k[$];
    int pulse_k[$];
    logic [31:0] pulse_d[$];
    int busy;
    logic rdy;
    int sp_acc, sp_pulse;
    logic [31:0] d0, d1;
    busy = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.value    = 14'd7;
    bus.blank_lz = 1'b0;
    bus.dp_en    = 1'b0;
    bus.dp_pos   = 2'd0;
    rdy = bus.in_ready;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (rdy && bus.in_valid) begin
        acc_k.push_back(k);
        if (acc_k.size() == 1) bus.value = 14'd8000;
        else bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        pulse_k.push_back(k);
        pulse_d.push_back(bus.data_out);
      end
      if (!bus.in_ready) busy++;
      rdy = bus.in_ready;
    end
    bus.in_valid = 1'b0;
    sp_acc   = (acc_k.size() >= 2) ? acc_k[1] - acc_k[0] : -1;
    sp_pulse = (pulse_k.size() >= 2) ? pulse_k[1] - pulse_k[0] : -1;
    d0 = (pulse_d.size() >= 1) ? pulse_d[0] : 32'h0;
    d1 = (pulse_d.size() >= 2) ? pulse_d[1] : 32'h0;
    checks++; if (acc_k.size() !== 2) begin errors++; $display("[TB] FAIL b2b_accepts: got %0d expected 2", acc_k.size()); end
    checks++; if (sp_acc !== 16) begin errors++; $display("[TB] FAIL b2b_accept_spacing: got %0d expected 16", sp_acc); end
    checks++; if (pulse_k.size() !== 2) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", pulse_k.size()); end
    checks++; if (sp_pulse !== 16) begin errors++; $display("[TB] FAIL b2b_pulse_spacing: got %0d expected 16", sp_pulse); end
    checks++; if (d0 !== 32'h30303037) begin errors++; $display("[TB] FAIL b2b_first_data: got %h expected 30303037", d0); end
    checks++; if (d1 !== 32'h38303030) begin errors++; $display("[TB] FAIL b2b_second_data: got %h expected 38303030", d1); end
    checks++; if (busy !== 30) begin errors++; $display("[TB] FAIL b2b_busy_cycles: got %0d expected 30", busy); end
  endtask

  task automatic test_mid_reset();
    int lat, busy; logic [31:0] d; logic [3:0] dt; logic ova;
    logic seen;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.value    = 14'd1234;
    bus.blank_lz = 1'b0;
    bus.dp_en    = 1'b1;
    bus.dp_pos   = 2'd1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.data_out !== 32'h20202020) begin errors++; $display("[TB] FAIL midrst_data: got %h expected 20202020", bus.data_out); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_pulse: out_valid seen %b expected 0", seen); end
    run_conv(14'd42, 1'b0, 1'b0, 2'd0, lat, busy, d, dt, ova);
    checks++; if (d !== 32'h30303432) begin errors++; $display("[TB] FAIL midrst_fresh_data: got %h expected 30303432", d); end
    checks++; if (lat !== 15) begin errors++; $display("[TB] FAIL midrst_fresh_latency: got %0d expected 15", lat); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_plain();
    test_blanking();
    test_decimal_point();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2dec_fmt.md
# bin2dec_fmt

Converts a 14-bit unsigned binary value into four ASCII decimal characters plus a decimal-point mask, ready to drive the 4-digit seven-segment display driver's `data_in[31:0]` / `dot_in[3:0]` inputs. Conversion is sequential shift-add-3 (double dabble), one bit per clock, behind a valid/ready handshake. The block holds its last result, so the display driver can sample it continuously.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz, for documentation only; no logic depends on it.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request carries a new value.
- `in_ready`  out  1  block is idle and will accept a request this cycle.
- `value`  in  14  unsigned binary value to display; valid range is 0..9999.
- `blank_lz`  in  1  when 1, replace leading zeros with spaces.
- `dp_en`  in  1  enables the decimal point.
- `dp_pos`  in  2  digit index carrying the decimal point (0 = ones digit).
- `data_out`  out  32  four ASCII characters. Byte i (`[i*8 +: 8]`) is digit i; byte 0 is the ones digit and byte 3 is the thousands digit.
- `dot_out`  out  4  decimal-point mask; bit i belongs to digit i.
- `out_valid`  out  1  one-cycle pulse when `data_out` / `dot_out` have just been updated.

## Operation
- The FSM has three states: IDLE, SHIFT and FMT.
- `in_ready` = (state == IDLE). It is decoded from the state register and does not depend on `in_valid`.
- Accept occurs when `in_valid && in_ready` at a clock edge. On accept:
  - latch `value`, `blank_lz`, `dp_en` and `dp_pos`;
  - load a 30-bit shift register with {16'd0, value};
  - clear the iteration counter;
  - go to SHIFT.
- SHIFT performs 14 iterations, one per clock. In each iteration:
  - every 4-bit BCD nibble ≥ 5 has 3 added to it;
  - the whole 30-bit register then shifts left by 1.
  - After iteration 14, go to FMT.
- FMT is a single cycle. It registers the outputs, pulses `out_valid` and returns to IDLE.
- Overflow: if the latched value > 9999, FMT writes `data_out` = 32'h2D2D2D2D ("----") and `dot_out` = 4'b0000. The full conversion still runs, so latency is unchanged.
- Digit encoding: digit d maps to 8'h30 + d.
- Leading-zero blanking, applied only when `blank_lz` = 1:
  - Scan from digit 3 downward. Each zero digit becomes 8'h20 until the first nonzero digit.
  - Digit 0 is never blanked.
  - When `dp_en` = 1, digit `dp_pos` and every digit below it are never blanked.
- `dot_out` = `dp_en` ? (4'b0001 << `dp_pos`) : 4'b0000, unless the value overflowed.
- `data_out` and `dot_out` hold their values between updates.
- Inputs are ignored while `in_ready` = 0. No request is queued.

## Timing
- Reset values:
  - state IDLE, so `in_ready` = 1;
  - `data_out` = 32'h20202020 (four spaces);
  - `dot_out` = 4'b0000;
  - `out_valid` = 0;
  - shift register and iteration counter = 0.
- Latency: if accept happens at edge N, SHIFT occupies edges N+1..N+14. Edge N+15 (FMT) updates `data_out` and `dot_out` and sets `out_valid` = 1 for the cycle that follows it.
- `in_ready` returns to 1 in that same cycle, so with `in_valid` held high the next accept occurs at edge N+16. Maximum throughput is one conversion per 16 clocks.
- `out_valid` is high for exactly one cycle per accepted request.
- Reset asserted mid-conversion aborts the conversion. No `out_valid` is produced and the outputs return to their reset values.
- `value` changing while the block is busy has no effect.

## Test plan
- Plain conversion: `value`=1234, `blank_lz`=0, `dp_en`=0 → 15 cycles after accept, `data_out`=32'h31323334, `dot_out`=4'b0000, `out_valid` high for 1 cycle.
- Leading-zero blanking: `value`=42, `blank_lz`=1 → `data_out`=32'h20203432. Then `value`=0, `blank_lz`=1 → `data_out`=32'h20202030.
- Blanking with decimal point: `value`=5, `blank_lz`=1, `dp_en`=1, `dp_pos`=2 → `data_out`=32'h20303035, `dot_out`=4'b0100.
- Boundary and overflow:
  - 9999 → 32'h39393939;
  - 10000 → 32'h2D2D2D2D with `dot_out`=0;
  - 16383 → 32'h2D2D2D2D.
- Back-to-back requests: hold `in_valid`=1 with values 7 then 8000 → accepts are 16 cycles apart, `in_ready` is low for 15 cycles after each accept, and exactly two `out_valid` pulses occur with `data_out` = 32'h30303037 then 32'h38303030.
- Mid-conversion reset: assert `rst_n`=0 five cycles after accept → `data_out`=32'h20202020, no `out_valid` pulse, `in_ready`=1 immediately; a fresh request then converts correctly.
